alu_seq_ctrl: RTL and testbench
===============================

// Module: alu_seq_ctrl
// PURPOSE
//  Parametrised successor to the single-cycle ALU decoder: decodes Funct, executes the operation and owns the NZCV flags.
//  Flags sit in an architectural register, written conditionally under CondEx and FlagW.
//  Adds an iterative shift-add multiply mode with a start/busy/done handshake.
//  Sits between the main decoder/condition unit and the datapath of the multicycle core.
// PARAMETERS
//  WIDTH   32  operand/result width in bits (>=4)
//  MUL_EN  1   1 = multiply mode implemented; 0 = mul requests flagged illegal
// PORTS
//  clk        in   1      clock, rising edge
//  reset_n    in   1      asynchronous, active-low reset
//  start      in   1      request; accepted only when busy=0
//  ALUOp      in   1      0 = plain ADD (address calc), no flag write; 1 = decode Funct
//  Funct      in   5      [4:1] cmd, [0] S bit
//  mul        in   1      1 = multiply request (overrides Funct[4:1]; Funct[0] still = S)
//  CondEx     in   1      condition passed; gates all flag writes
//  SrcA       in   WIDTH  operand A
//  SrcB       in   WIDTH  operand B
//  ALUResult  out  WIDTH  registered result, held until next completion
//  Flags      out  4      registered {N,Z,C,V}
//  busy       out  1      operation in flight
//  done       out  1      one-cycle completion pulse
//  illegal    out  1      one-cycle pulse with done for an undefined request
// BEHAVIOUR
//  Reset: all outputs 0, FSM to IDLE; applies asynchronously, including mid-operation (op aborted, nothing written).
//  Operand capture: on an accepted start, SrcA, SrcB, Funct, ALUOp, mul and CondEx are latched; later input changes are ignored.
//  FSM states:
//   IDLE: start=1 -> EXEC, or MUL if (mul and MUL_EN and ALUOp).
//   EXEC: one cycle -> IDLE with done=1.
//   MUL: iterates WIDTH cycles -> IDLE with done=1 on the last cycle.
//  start while busy=1: ignored, no queueing.
//  Latency, start edge to done high: EXEC = 1 cycle; MUL = WIDTH cycles. busy=1 from the accepted start edge until the done cycle inclusive.
//  ALUOp=0: ADD, FlagW=00.
//  Cmd decode (ALUOp=1):
//   ADD=0100, SUB=0010, CMP=1010 (SUB, result discarded, flags always written), AND=0000, EOR=0001, ORR=1100, MOV=1101 (B).
//   Any other cmd: illegal=1, ALUResult unchanged, no flag write.
//  FlagW:
//   ADD/SUB with S=1: 11 (NZ and CV).
//   CMP: 11 regardless of S.
//   Logical/MOV with S=1: 10 (NZ only).
//   S=0: 00.
//  Flag write occurs on the done cycle only, and only if the latched CondEx=1. FlagW[1] updates N,Z; FlagW[0] updates C,V.
//  Arithmetic:
//   WIDTH+1-bit sum. C = carry-out. SUB computes A + ~B + 1, so C = NOT borrow.
//   V = (A[msb]==B'[msb]) && (R[msb]!=A[msb]), where B' is the effective B.
//   N = R[WIDTH-1]; Z = (R==0).
//  MUL:
//   Result = low WIDTH bits of A*B, unsigned.
//   S=1 updates NZ only; C and V are preserved.
//   MUL_EN=0: mul request completes as EXEC with illegal=1.
//  ALUResult updates on done, except for CMP and illegal requests.
// STRUCTURE
//  Package alu_pkg:
//   cmd encodings as localparams, ALUControl codes, FlagW codes.
//   state enum {IDLE, EXEC, MUL}.
//   flag bit indices N=3, Z=2, C=1, V=0.
//  Sub-module alu_mul_iter #(WIDTH): shift-add multiplier.
//   Ports: clk, reset_n, load, a, b, product, last.
//   Instantiate only when MUL_EN=1 (generate).
//  Decode, ALU core and flag register stay in this module.
// TESTING (WIDTH=32)
//  ADD 0x7FFFFFFF+0x1, S=1, CondEx=1 -> done 1 cycle after start, ALUResult=0x80000000, Flags=1001.
//  SUB 5-5, S=1 -> ALUResult=0, Flags=0110. Then CMP 3 vs 5 -> ALUResult stays 0, Flags=1000.
//  AND 0xF0F0&0x0FF0, S=1, CondEx=0 -> ALUResult=0x00F0, Flags unchanged. ALUOp=0 ADD 4+4 -> 8, Flags unchanged.
//  MUL 0xFFFF*0x10001, S=1 -> busy 32 cycles, done at cycle 32, ALUResult=0xFFFFFFFF, N=1 Z=0, C/V preserved. start pulsed mid-op is ignored.
//  reset_n low at MUL cycle 10 -> busy/done/ALUResult/Flags=0 at once. Next ADD 1+2 -> 3 after 1 cycle.
//  Funct cmd 0111 -> illegal=1 and done=1 same cycle, ALUResult and Flags unchanged. MUL_EN=0 mul -> illegal=1 after 1 cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared encodings for alu_seq_ctrl: command codes, internal
//                ALU control codes, flag-write codes, FSM states, flag indices.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    // Funct[4:1] command encodings
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    // Internal ALU control codes
    localparam logic [2:0] ALUC_ADD = 3'd0;
    localparam logic [2:0] ALUC_SUB = 3'd1;
    localparam logic [2:0] ALUC_AND = 3'd2;
    localparam logic [2:0] ALUC_ORR = 3'd3;
    localparam logic [2:0] ALUC_EOR = 3'd4;
    localparam logic [2:0] ALUC_MOV = 3'd5;

    // FlagW codes: bit 1 enables N/Z, bit 0 enables C/V
    localparam logic [1:0] FLAGW_NONE = 2'b00;
    localparam logic [1:0] FLAGW_NZ   = 2'b10;
    localparam logic [1:0] FLAGW_NZCV = 2'b11;

    // Flag bit positions inside the {N,Z,C,V} register
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/alu_mul_iter.sv
// ============================================================================
//  Module      : alu_mul_iter
//  Description : Iterative shift-add unsigned multiplier, one partial product
//                per cycle. 'product' presents the accumulator including the
//                current step, so it is final while 'last' is high.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] product,
    output logic             last
);

    localparam int c_cnt_w = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [c_cnt_w-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   w_acc_next;

    assign w_acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign product    = w_acc_next;
    assign last       = (cnt_q == c_cnt_w'(WIDTH - 1));

    // Load operands, otherwise add one partial product and shift
    always_comb begin
        acc_d    = w_acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (load) begin
            acc_d    = '0;
            mcand_d  = a;
            mplier_d = b;
            cnt_d    = '0;
        end
    end

    // Iteration state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_seq_ctrl.sv
// ============================================================================
//  Module      : alu_seq_ctrl
//  Description : Sequenced ALU: Funct decode, ALU core, NZCV flag register
//                and optional iterative multiply with start/busy/done.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_seq_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             ALUOp,
    input  logic [4:0]       Funct,
    input  logic             mul,
    input  logic             CondEx,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic [WIDTH-1:0] ALUResult,
    output logic [3:0]       Flags,
    output logic             busy,
    output logic             done,
    output logic             illegal
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [4:0]       funct_q, funct_d;
    logic             aluop_q, aluop_d, mul_q, mul_d, condex_q, condex_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;
    logic             busy_q, busy_d, done_q, done_d, illegal_q, illegal_d;

    logic             w_accept, w_mul_go, w_mul_load, w_mul_last;
    logic [WIDTH-1:0] w_mul_product;
    logic [2:0]       w_alu_ctrl;
    logic [1:0]       w_flag_w;
    logic             w_illegal, w_wr_result;
    logic [WIDTH-1:0] w_b_eff, w_alu_res, w_final;
    logic [WIDTH:0]   w_sum;
    logic             w_is_sub, w_carry, w_ovf;

    assign w_accept   = start & ~busy_q;
    assign w_mul_go   = mul & ALUOp & MUL_EN;
    assign w_mul_load = w_accept & w_mul_go;

    generate
        if (MUL_EN) begin : g_mul
            alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
                .clk     (clk),
                .reset_n (reset_n),
                .load    (w_mul_load),
                .a       (SrcA),
                .b       (SrcB),
                .product (w_mul_product),
                .last    (w_mul_last)
            );
        end else begin : g_no_mul
            assign w_mul_product = '0;
            assign w_mul_last    = 1'b0;
        end
    endgenerate

    // Decode the latched request into ALU control, flag-write mask and legality
    always_comb begin
        w_alu_ctrl  = ALUC_ADD;
        w_flag_w    = FLAGW_NONE;
        w_illegal   = 1'b0;
        w_wr_result = 1'b1;
        if (aluop_q) begin
            if (mul_q) begin
                if (MUL_EN) begin
                    w_flag_w = funct_q[0] ? FLAGW_NZ : FLAGW_NONE;
                end else begin
                    w_illegal   = 1'b1;
                    w_wr_result = 1'b0;
                end
            end else begin
                case (funct_q[4:1])
                    CMD_ADD: begin
                        w_alu_ctrl = ALUC_ADD;
                        w_flag_w   = funct_q[0] ? FLAGW_NZCV : FLAGW_NONE;
                    end
                    CMD_SUB: begin
                        w_alu_ctrl = ALUC_SUB;
                        w_flag_w   = funct_q[0] ? FLAGW_NZCV : FLAGW_NONE;
                    end
                    CMD_CMP: begin
                        // compare only: flags always, result discarded
                        w_alu_ctrl  = ALUC_SUB;
                        w_flag_w    = FLAGW_NZCV;
                        w_wr_result = 1'b0;
                    end
                    CMD_AND: begin
                        w_alu_ctrl = ALUC_AND;
                        w_flag_w   = funct_q[0] ? FLAGW_NZ : FLAGW_NONE;
                    end
                    CMD_EOR: begin
                        w_alu_ctrl = ALUC_EOR;
                        w_flag_w   = funct_q[0] ? FLAGW_NZ : FLAGW_NONE;
                    end
                    CMD_ORR: begin
                        w_alu_ctrl = ALUC_ORR;
                        w_flag_w   = funct_q[0] ? FLAGW_NZ : FLAGW_NONE;
                    end
                    CMD_MOV: begin
                        w_alu_ctrl = ALUC_MOV;
                        w_flag_w   = funct_q[0] ? FLAGW_NZ : FLAGW_NONE;
                    end
                    default: begin
                        w_illegal   = 1'b1;
                        w_wr_result = 1'b0;
                    end
                endcase
            end
        end
    end

    // ALU core: subtraction is A + ~B + 1 so carry-out reads as NOT borrow
    assign w_is_sub = (w_alu_ctrl == ALUC_SUB);
    assign w_b_eff  = w_is_sub ? ~b_q : b_q;
    assign w_sum    = {1'b0, a_q} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_is_sub};
    assign w_carry  = w_sum[WIDTH];
    assign w_ovf    = (a_q[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                      (w_sum[WIDTH-1] != a_q[WIDTH-1]);

    // Select the logical/arithmetic result for the decoded control code
    always_comb begin
        w_alu_res = w_sum[WIDTH-1:0];
        case (w_alu_ctrl)
            ALUC_AND: w_alu_res = a_q & b_q;
            ALUC_ORR: w_alu_res = a_q | b_q;
            ALUC_EOR: w_alu_res = a_q ^ b_q;
            ALUC_MOV: w_alu_res = b_q;
            default:  w_alu_res = w_sum[WIDTH-1:0];
        endcase
    end

    assign w_final = (state_q == MUL) ? w_mul_product : w_alu_res;

    // FSM next state, operand capture and completion write-back
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        funct_d   = funct_q;
        aluop_d   = aluop_q;
        mul_d     = mul_q;
        condex_d  = condex_q;
        result_d  = result_q;
        flags_d   = flags_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        illegal_d = 1'b0;
        case (state_q)
            IDLE: begin
                // busy is only still high here during the done cycle
                busy_d = 1'b0;
                if (w_accept) begin
                    a_d      = SrcA;
                    b_d      = SrcB;
                    funct_d  = Funct;
                    aluop_d  = ALUOp;
                    mul_d    = mul;
                    condex_d = CondEx;
                    busy_d   = 1'b1;
                    state_d  = w_mul_go ? MUL : EXEC;
                end
            end
            EXEC, MUL: begin
                if ((state_q == EXEC) || w_mul_last) begin
                    state_d   = IDLE;
                    done_d    = 1'b1;
                    illegal_d = w_illegal;
                    if (w_wr_result) begin
                        result_d = w_final;
                    end
                    if (condex_q && w_flag_w[1]) begin
                        flags_d[FLAG_N] = w_final[WIDTH-1];
                        flags_d[FLAG_Z] = (w_final == '0);
                    end
                    if (condex_q && w_flag_w[0]) begin
                        flags_d[FLAG_C] = w_carry;
                        flags_d[FLAG_V] = w_ovf;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, captured request and architectural outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            funct_q   <= '0;
            aluop_q   <= 1'b0;
            mul_q     <= 1'b0;
            condex_q  <= 1'b0;
            result_q  <= '0;
            flags_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            funct_q   <= funct_d;
            aluop_q   <= aluop_d;
            mul_q     <= mul_d;
            condex_q  <= condex_d;
            result_q  <= result_d;
            flags_q   <= flags_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
        end
    end

    assign ALUResult = result_q;
    assign Flags     = flags_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign illegal   = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq_ctrl.sv
// ============================================================================
//  Module      : tb_alu_seq_ctrl
//  Description : Self-checking bench for alu_seq_ctrl (WIDTH=32), with a
//                second MUL_EN=0 instance for the disabled-multiply case.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_seq_ctrl;

    logic        clk;
    logic        reset_n;
    logic        start, start_nm;
    logic        ALUOp, mul, CondEx;
    logic [4:0]  Funct;
    logic [31:0] SrcA, SrcB;
    logic [31:0] ALUResult, ALUResult_nm;
    logic [3:0]  Flags, Flags_nm;
    logic        busy, done, illegal;
    logic        busy_nm, done_nm, illegal_nm;

    int total = 0;
    int bad   = 0;

    // reference architectural state
    logic [31:0] ref_res;
    logic [3:0]  ref_flags;

    alu_seq_ctrl #(.WIDTH(32), .MUL_EN(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .ALUOp(ALUOp),
        .Funct(Funct), .mul(mul), .CondEx(CondEx), .SrcA(SrcA), .SrcB(SrcB),
        .ALUResult(ALUResult), .Flags(Flags), .busy(busy), .done(done),
        .illegal(illegal)
    );

    alu_seq_ctrl #(.WIDTH(32), .MUL_EN(1'b0)) dut_nm (
        .clk(clk), .reset_n(reset_n), .start(start_nm), .ALUOp(ALUOp),
        .Funct(Funct), .mul(mul), .CondEx(CondEx), .SrcA(SrcA), .SrcB(SrcB),
        .ALUResult(ALUResult_nm), .Flags(Flags_nm), .busy(busy_nm),
        .done(done_nm), .illegal(illegal_nm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: applies one request to ref_res/ref_flags
    task automatic model_op(input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] f, input logic aop,
                            input logic m, input logic ce,
                            output bit ill, output int lat);
        logic [3:0]  cmd;
        logic [32:0] wide;
        logic [31:0] r;
        longint      sa, sb, sr;
        bit          s, wr, wnz, wcv, c, v;
        cmd = f[4:1]; s = f[0];
        ill = 0; lat = 1; wr = 1; wnz = 0; wcv = 0; c = 0; v = 0; r = '0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!aop) begin
            r = a + b;
        end else if (m) begin
            r = 32'(64'(a) * 64'(b));
            lat = 32;
            wnz = s;
        end else begin
            case (cmd)
                4'b0100: begin
                    wide = {1'b0, a} + {1'b0, b};
                    r = wide[31:0]; c = wide[32];
                    sr = sa + sb; v = (sr != longint'($signed(r)));
                    wnz = s; wcv = s;
                end
                4'b0010, 4'b1010: begin
                    r = a - b; c = (a >= b);
                    sr = sa - sb; v = (sr != longint'($signed(r)));
                    wnz = s || (cmd == 4'b1010); wcv = wnz;
                    wr = (cmd != 4'b1010);
                end
                4'b0000: begin r = a & b; wnz = s; end
                4'b0001: begin r = a ^ b; wnz = s; end
                4'b1100: begin r = a | b; wnz = s; end
                4'b1101: begin r = b;     wnz = s; end
                default: begin ill = 1; wr = 0; end
            endcase
        end
        if (wr) ref_res = r;
        if (ce && wnz) begin ref_flags[3] = r[31]; ref_flags[2] = (r == 0); end
        if (ce && wcv) begin ref_flags[1] = c; ref_flags[0] = v; end
    endtask

    // Issue one request, scramble inputs while busy, check the completion
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] f, input logic aop,
                          input logic m, input logic ce, input string tag);
        bit ill_exp;
        int lat_exp, lat;
        model_op(a, b, f, aop, m, ce, ill_exp, lat_exp);
        @(negedge clk);
        SrcA = a; SrcB = b; Funct = f; ALUOp = aop; mul = m; CondEx = ce;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        SrcA = $urandom; SrcB = $urandom; Funct = 5'($urandom);
        ALUOp = 1'($urandom); mul = 1'($urandom); CondEx = 1'($urandom);
        total++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL %s accept: busy=%b done=%b, required busy=1 done=0", tag, busy, done);
        end
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        total++;
        if (lat !== lat_exp) begin
            bad++;
            $display("FAIL %s latency: got %0d, required %0d", tag, lat, lat_exp);
        end
        total++;
        if (illegal !== ill_exp || busy !== 1'b1) begin
            bad++;
            $display("FAIL %s done-cycle: illegal=%b busy=%b, required illegal=%b busy=1", tag, illegal, busy, ill_exp);
        end
        total++;
        if (ALUResult !== ref_res) begin
            bad++;
            $display("FAIL %s result: got %h, required %h", tag, ALUResult, ref_res);
        end
        total++;
        if (Flags !== ref_flags) begin
            bad++;
            $display("FAIL %s flags: got %b, required %b", tag, Flags, ref_flags);
        end
    endtask

    task automatic test_reset();
        total++;
        if (ALUResult !== 32'h0 || Flags !== 4'h0 || busy !== 1'b0 ||
            done !== 1'b0 || illegal !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: res=%h flags=%b busy=%b done=%b illegal=%b, required all 0",
                     ALUResult, Flags, busy, done, illegal);
        end
    endtask

    task automatic test_directed();
        run_op(32'h7FFF_FFFF, 32'h1, 5'b0100_1, 1'b1, 1'b0, 1'b1, "add_ovf");
        total++;
        if (ALUResult !== 32'h8000_0000 || Flags !== 4'b1001) begin
            bad++;
            $display("FAIL add_ovf_lit: res=%h flags=%b, required 80000000/1001", ALUResult, Flags);
        end
        run_op(32'd5, 32'd5, 5'b0010_1, 1'b1, 1'b0, 1'b1, "sub_zero");
        total++;
        if (ALUResult !== 32'h0 || Flags !== 4'b0110) begin
            bad++;
            $display("FAIL sub_zero_lit: res=%h flags=%b, required 0/0110", ALUResult, Flags);
        end
        run_op(32'd3, 32'd5, 5'b1010_0, 1'b1, 1'b0, 1'b1, "cmp");
        total++;
        if (ALUResult !== 32'h0 || Flags !== 4'b1000) begin
            bad++;
            $display("FAIL cmp_lit: res=%h flags=%b, required 0/1000", ALUResult, Flags);
        end
        run_op(32'hF0F0, 32'h0FF0, 5'b0000_1, 1'b1, 1'b0, 1'b0, "and_nocond");
        total++;
        if (ALUResult !== 32'h00F0 || Flags !== 4'b1000) begin
            bad++;
            $display("FAIL and_nocond_lit: res=%h flags=%b, required 000000f0/1000", ALUResult, Flags);
        end
        run_op(32'd4, 32'd4, 5'b0111_1, 1'b0, 1'b0, 1'b1, "aluop0_add");
        total++;
        if (ALUResult !== 32'd8 || Flags !== 4'b1000) begin
            bad++;
            $display("FAIL aluop0_lit: res=%h flags=%b, required 8/1000", ALUResult, Flags);
        end
        run_op(32'd9, 32'd9, 5'b0111_1, 1'b1, 1'b0, 1'b1, "illegal_cmd");
        total++;
        if (ALUResult !== 32'd8 || Flags !== 4'b1000) begin
            bad++;
            $display("FAIL illegal_lit: res=%h flags=%b, required 8/1000", ALUResult, Flags);
        end
    endtask

    task automatic test_mul();
        bit ill_exp;
        int lat_exp, cyc;
        bit seen;
        // give C and V known 1 values so preservation is visible
        run_op(32'h8000_0000, 32'h8000_0000, 5'b0100_1, 1'b1, 1'b0, 1'b1, "pre_mul_add");
        model_op(32'h0000_FFFF, 32'h0001_0001, 5'b0000_1, 1'b1, 1'b1, 1'b1, ill_exp, lat_exp);
        @(negedge clk);
        SrcA = 32'h0000_FFFF; SrcB = 32'h0001_0001; Funct = 5'b0000_1;
        ALUOp = 1'b1; mul = 1'b1; CondEx = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0; seen = 0;
        while (!seen && cyc < 64) begin
            @(negedge clk);
            cyc++;
            if (cyc == 5) begin
                start = 1'b1; SrcA = 32'd1; SrcB = 32'd1; mul = 1'b0; Funct = 5'b0100_1;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) seen = 1;
        end
        start = 1'b0;
        total++;
        if (cyc !== lat_exp) begin
            bad++;
            $display("FAIL mul_latency: got %0d, required %0d", cyc, lat_exp);
        end
        total++;
        if (ALUResult !== 32'hFFFF_FFFF || Flags !== 4'b1011 || Flags !== ref_flags) begin
            bad++;
            $display("FAIL mul_result: res=%h flags=%b, required ffffffff/1011", ALUResult, Flags);
        end
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || ALUResult !== ref_res) begin
            bad++;
            $display("FAIL mul_no_queue: busy=%b done=%b res=%h, required 0/0/%h", busy, done, ALUResult, ref_res);
        end
    endtask

    task automatic test_reset_mid_mul();
        @(negedge clk);
        SrcA = 32'h1234_5678; SrcB = 32'h9ABC_DEF1; Funct = 5'b0000_1;
        ALUOp = 1'b1; mul = 1'b1; CondEx = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || ALUResult !== 32'h0 || Flags !== 4'h0) begin
            bad++;
            $display("FAIL async_reset: busy=%b done=%b res=%h flags=%b, required all 0",
                     busy, done, ALUResult, Flags);
        end
        ref_res = '0; ref_flags = '0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        run_op(32'd1, 32'd2, 5'b0100_0, 1'b1, 1'b0, 1'b1, "post_reset_add");
        total++;
        if (ALUResult !== 32'd3) begin
            bad++;
            $display("FAIL post_reset_lit: got %h, required 3", ALUResult);
        end
    endtask

    task automatic test_mul_disabled();
        @(negedge clk);
        SrcA = 32'd7; SrcB = 32'd6; Funct = 5'b0100_1;
        ALUOp = 1'b1; mul = 1'b1; CondEx = 1'b1; start_nm = 1'b1;
        @(negedge clk);
        start_nm = 1'b0;
        total++;
        if (busy_nm !== 1'b1 || done_nm !== 1'b0) begin
            bad++;
            $display("FAIL nomul_accept: busy=%b done=%b, required 1/0", busy_nm, done_nm);
        end
        @(negedge clk);
        total++;
        if (done_nm !== 1'b1 || illegal_nm !== 1'b1 || ALUResult_nm !== 32'h0 || Flags_nm !== 4'h0) begin
            bad++;
            $display("FAIL nomul_done: done=%b illegal=%b res=%h flags=%b, required 1/1/0/0",
                     done_nm, illegal_nm, ALUResult_nm, Flags_nm);
        end
        @(negedge clk);
        total++;
        if (done_nm !== 1'b0 || illegal_nm !== 1'b0 || busy_nm !== 1'b0) begin
            bad++;
            $display("FAIL nomul_pulse: done=%b illegal=%b busy=%b, required 0/0/0", done_nm, illegal_nm, busy_nm);
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        logic [3:0] valid_cmds [7];
        logic [3:0] cmd;
        logic       m;
        valid_cmds = '{4'b0100, 4'b0010, 4'b1010, 4'b0000, 4'b0001, 4'b1100, 4'b1101};
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) < 8) cmd = valid_cmds[$urandom_range(0, 6)];
            else                          cmd = 4'($urandom);
            m = ($urandom_range(0, 4) == 0);
            run_op(pick_operand(), pick_operand(), {cmd, 1'($urandom)},
                   ($urandom_range(0, 5) != 0), m, 1'($urandom), "random");
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; start = 1'b0; start_nm = 1'b0;
        ALUOp = 1'b0; mul = 1'b0; CondEx = 1'b0; Funct = '0;
        SrcA = '0; SrcB = '0;
        ref_res = '0; ref_flags = '0;
        repeat (3) @(negedge clk);
        test_reset();
        reset_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_directed();
        test_mul();
        test_reset_mid_mul();
        test_mul_disabled();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
